// File: rtl/id_ex_cond_stage.sv
// id_ex_cond_stage
//   Execute-stage front end of the pipelined ARM core. Holds the ID/EX
//   pipeline register (decode control bundle + operand data), evaluates the
//   instruction condition field against the architectural NZCV register,
//   updates that register, and produces condition-gated strobes for the
//   EX/MEM register and the hazard unit.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   StallE, FlushE             hold E registers / load a bubble into E
//   *D                         decode-side controls and operand data
//   ALUFlags                   {N,Z,C,V} from the E-stage ALU, same cycle
//   MemtoRegE .. WA3E          registered controls and data
//   CondExE                    condition passed for the instruction in E
//   RegWriteE, MemWriteE,
//   PCSrcE, BranchTakenE       condition-gated strobes
//   Flags                      architectural {N,Z,C,V}
//
// Pipeline control: there is no valid/ready pair here. StallE holds every
// E register (including Flags) for the cycle; FlushE replaces the incoming
// instruction with a bubble. Priority at each edge is reset > FlushE >
// StallE > load. A bubble carries CondE = AL and all strobes at 0.
module id_ex_cond_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             PCSD,
  input  logic             RegWD,
  input  logic             MemWD,
  input  logic             MemtoRegD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic             NoWriteD,
  input  logic             IgRnD,
  input  logic [1:0]       FlagWD,
  input  logic [4:0]       ALUControlD,
  input  logic [3:0]       CondD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [3:0]       WA3D,
  input  logic [3:0]       ALUFlags,
  output logic             MemtoRegE,
  output logic             ALUSrcE,
  output logic             IgRnE,
  output logic [4:0]       ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [3:0]       WA3E,
  output logic             CondExE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             PCSrcE,
  output logic             BranchTakenE,
  output logic [3:0]       Flags
);

  localparam logic [3:0] COND_AL = 4'b1110;

  logic [3:0] CondE;
  logic       PCSE;
  logic       RegWE;
  logic       MemWE;
  logic       BranchE;
  logic [1:0] FlagWE;
  logic       NoWriteE;

  // ID/EX register. Reset and flush both produce the bubble encoding.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      CondE       <= COND_AL;
      PCSE        <= 1'b0;
      RegWE       <= 1'b0;
      MemWE       <= 1'b0;
      BranchE     <= 1'b0;
      FlagWE      <= 2'b00;
      NoWriteE    <= 1'b0;
      MemtoRegE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      IgRnE       <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
      WA3E        <= '0;
    end else if (!StallE) begin
      CondE       <= CondD;
      PCSE        <= PCSD;
      RegWE       <= RegWD;
      MemWE       <= MemWD;
      BranchE     <= BranchD;
      FlagWE      <= FlagWD;
      NoWriteE    <= NoWriteD;
      MemtoRegE   <= MemtoRegD;
      ALUSrcE     <= ALUSrcD;
      IgRnE       <= IgRnD;
      ALUControlE <= ALUControlD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ExtImmE     <= ExtImmD;
      WA3E        <= WA3D;
    end
  end

  // Condition evaluation against the architectural flags.
  logic flag_n, flag_z, flag_c, flag_v;
  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];

  always_comb begin
    CondExE = 1'b0;
    unique case (CondE)
      4'b0000: CondExE = flag_z;
      4'b0001: CondExE = !flag_z;
      4'b0010: CondExE = flag_c;
      4'b0011: CondExE = !flag_c;
      4'b0100: CondExE = flag_n;
      4'b0101: CondExE = !flag_n;
      4'b0110: CondExE = flag_v;
      4'b0111: CondExE = !flag_v;
      4'b1000: CondExE = flag_c && !flag_z;
      4'b1001: CondExE = !flag_c || flag_z;
      4'b1010: CondExE = (flag_n == flag_v);
      4'b1011: CondExE = (flag_n != flag_v);
      4'b1100: CondExE = !flag_z && (flag_n == flag_v);
      4'b1101: CondExE = flag_z || (flag_n != flag_v);
      4'b1110: CondExE = 1'b1;
      4'b1111: CondExE = 1'b0;
      default: CondExE = 1'b0;
    endcase
  end

  // NoWrite suppresses the register write and the PC write (CMP/TST style).
  assign RegWriteE    = RegWE && CondExE && !NoWriteE;
  assign MemWriteE    = MemWE && CondExE;
  assign PCSrcE       = PCSE && CondExE && !NoWriteE;
  assign BranchTakenE = BranchE && CondExE;

  // Architectural flags. FlushE deliberately does not gate this: the
  // instruction currently in E still commits its flags while the bubble
  // is loaded behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (!StallE && CondExE) begin
      if (FlagWE[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWE[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_id_ex_cond_stage.sv
module tb_id_ex_cond_stage;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic             pcs;
    logic             regw;
    logic             memw;
    logic             memtoreg;
    logic             alusrc;
    logic             branch;
    logic             nowrite;
    logic             ign;
    logic [1:0]       flagw;
    logic [4:0]       aluctl;
    logic [3:0]       cond;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [3:0]       wa3;
  } instr_t;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp_pass;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] alu_flags = 4'b0000;
  instr_t     d = '0;

  logic             MemtoRegE, ALUSrcE, IgRnE;
  logic [4:0]       ALUControlE;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE;
  logic [3:0]       WA3E;
  logic             CondExE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE;
  logic [3:0]       Flags;

  id_ex_cond_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush),
    .PCSD(d.pcs), .RegWD(d.regw), .MemWD(d.memw), .MemtoRegD(d.memtoreg),
    .ALUSrcD(d.alusrc), .BranchD(d.branch), .NoWriteD(d.nowrite), .IgRnD(d.ign),
    .FlagWD(d.flagw), .ALUControlD(d.aluctl), .CondD(d.cond),
    .RD1D(d.rd1), .RD2D(d.rd2), .ExtImmD(d.imm), .WA3D(d.wa3),
    .ALUFlags(alu_flags),
    .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .IgRnE(IgRnE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .WA3E(WA3E), .CondExE(CondExE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
    .Flags(Flags)
  );

  // ---------------- reference model ----------------
  instr_t     m_e;
  logic [3:0] m_flags;
  int         checks = 0;
  int         failures = 0;

  function automatic instr_t bubble();
    instr_t b;
    b = '0;
    b.cond = 4'b1110;
    return b;
  endfunction

  // ARM rule: cond[3:1] picks a base predicate, cond[0] inverts it.
  // AL (1110) is "always"; its inverse 1111 is therefore "never".
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x.pcs      = 1'($urandom_range(0, 1));
    x.regw     = 1'($urandom_range(0, 1));
    x.memw     = 1'($urandom_range(0, 1));
    x.memtoreg = 1'($urandom_range(0, 1));
    x.alusrc   = 1'($urandom_range(0, 1));
    x.branch   = 1'($urandom_range(0, 1));
    x.nowrite  = 1'($urandom_range(0, 1));
    x.ign      = 1'($urandom_range(0, 1));
    x.flagw    = 2'($urandom_range(0, 3));
    x.aluctl   = 5'($urandom_range(0, 31));
    x.cond     = 4'($urandom_range(0, 15));
    x.rd1      = $urandom;
    x.rd2      = $urandom;
    x.imm      = $urandom;
    x.wa3      = 4'($urandom_range(0, 15));
    return x;
  endfunction

  function automatic instr_t mk(input logic [3:0] cond, input logic [1:0] flagw,
                                input logic branch, input logic regw);
    instr_t x;
    x = bubble();
    x.cond   = cond;
    x.flagw  = flagw;
    x.branch = branch;
    x.regw   = regw;
    x.rd1    = $urandom;
    x.aluctl = 5'($urandom_range(0, 31));
    return x;
  endfunction

  // Model of one clock edge, using the inputs as they stand at the edge.
  task automatic model_edge();
    if (reset) begin
      m_flags = 4'b0000;
      m_e     = bubble();
    end else begin
      if (!stall && cond_pass(m_e.cond, m_flags)) begin
        if (m_e.flagw[1]) m_flags[3:2] = alu_flags[3:2];
        if (m_e.flagw[0]) m_flags[1:0] = alu_flags[1:0];
      end
      if (flush)       m_e = bubble();
      else if (!stall) m_e = d;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic p;
    p = cond_pass(m_e.cond, m_flags);
    chk("Flags", 32'(Flags), 32'(m_flags));
    chk("CondExE", 32'(CondExE), 32'(p));
    chk("RegWriteE", 32'(RegWriteE), 32'(m_e.regw && p && !m_e.nowrite));
    chk("MemWriteE", 32'(MemWriteE), 32'(m_e.memw && p));
    chk("PCSrcE", 32'(PCSrcE), 32'(m_e.pcs && p && !m_e.nowrite));
    chk("BranchTakenE", 32'(BranchTakenE), 32'(m_e.branch && p));
    chk("MemtoRegE", 32'(MemtoRegE), 32'(m_e.memtoreg));
    chk("ALUSrcE", 32'(ALUSrcE), 32'(m_e.alusrc));
    chk("IgRnE", 32'(IgRnE), 32'(m_e.ign));
    chk("ALUControlE", 32'(ALUControlE), 32'(m_e.aluctl));
    chk("RD1E", RD1E, m_e.rd1);
    chk("RD2E", RD2E, m_e.rd2);
    chk("ExtImmE", ExtImmE, m_e.imm);
    chk("WA3E", 32'(WA3E), 32'(m_e.wa3));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  vec_t vecs[256];

  initial begin
    m_e     = bubble();
    m_flags = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        vecs[c*16+f].cond     = 4'(c);
        vecs[c*16+f].flags    = 4'(f);
        vecs[c*16+f].exp_pass = cond_pass(4'(c), 4'(f));
      end
    end

    // Reset with random D inputs.
    reset = 1'b1;
    d = rand_instr(); alu_flags = 4'($urandom_range(0, 15));
    tick();
    d = rand_instr(); alu_flags = 4'($urandom_range(0, 15));
    tick();
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_regwrite", 32'(RegWriteE), 32'h0);
    chk("rst_memwrite", 32'(MemWriteE), 32'h0);
    chk("rst_pcsrc", 32'(PCSrcE), 32'h0);
    chk("rst_branch", 32'(BranchTakenE), 32'h0);
    chk("rst_condex", 32'(CondExE), 32'h1);
    chk("rst_rd1", RD1E, 32'h0);
    reset = 1'b0;
    d = bubble();
    tick();

    // SUBS then BEQ, Z set then Z clear.
    for (int k = 0; k < 2; k++) begin
      d = mk(4'b1110, 2'b11, 1'b0, 1'b1);
      tick();
      alu_flags = (k == 0) ? 4'b0100 : 4'b0000;
      d = mk(4'b0000, 2'b00, 1'b1, 1'b0);
      tick();
      chk("subs_flags", 32'(Flags), (k == 0) ? 32'h4 : 32'h0);
      chk("beq_taken", 32'(BranchTakenE), (k == 0) ? 32'h1 : 32'h0);
      d = bubble();
      tick();
    end

    // Partial flag write: 1111 then N,Z-only write of 0000.
    d = mk(4'b1110, 2'b11, 1'b0, 1'b0);
    tick();
    alu_flags = 4'b1111;
    d = mk(4'b1110, 2'b10, 1'b0, 1'b0);
    tick();
    chk("partial_pre", 32'(Flags), 32'hF);
    alu_flags = 4'b0000;
    d = bubble();
    tick();
    chk("partial_nz", 32'(Flags), 32'h3);
    // Same with a false condition (EQ with Z=0): no update.
    d = mk(4'b0000, 2'b11, 1'b0, 1'b0);
    tick();
    alu_flags = 4'b1100;
    d = bubble();
    tick();
    chk("partial_false", 32'(Flags), 32'h3);

    // NoWrite (CMP writing r15).
    d = mk(4'b1110, 2'b11, 1'b0, 1'b1);
    d.nowrite = 1'b1; d.wa3 = 4'd15; d.pcs = 1'b1;
    tick();
    chk("nowrite_regw", 32'(RegWriteE), 32'h0);
    chk("nowrite_pcsrc", 32'(PCSrcE), 32'h0);
    chk("nowrite_condex", 32'(CondExE), 32'h1);
    d = bubble();
    alu_flags = 4'b0000;
    tick();

    // Stall three cycles with a flag setter in E.
    d = mk(4'b1110, 2'b11, 1'b0, 1'b1);
    tick();
    stall = 1'b1;
    alu_flags = 4'b1010;
    for (int s = 0; s < 3; s++) begin
      d = rand_instr();
      tick();
      chk("stall_flags_hold", 32'(Flags), 32'h0);
    end
    stall = 1'b0;
    d = bubble();
    tick();
    chk("stall_release_flags", 32'(Flags), 32'hA);
    alu_flags = 4'b0101;
    tick();
    chk("stall_once", 32'(Flags), 32'hA);

    // Flush together with stall loads a bubble.
    d = rand_instr();
    d.cond = 4'b1110; d.regw = 1'b1; d.memw = 1'b1; d.pcs = 1'b1;
    d.branch = 1'b1; d.nowrite = 1'b0; d.flagw = 2'b00;
    tick();
    chk("pre_flush_memw", 32'(MemWriteE), 32'h1);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_regw", 32'(RegWriteE), 32'h0);
    chk("flush_memw", 32'(MemWriteE), 32'h0);
    chk("flush_pcsrc", 32'(PCSrcE), 32'h0);
    chk("flush_branch", 32'(BranchTakenE), 32'h0);
    chk("flush_condex", 32'(CondExE), 32'h1);
    stall = 1'b0; flush = 1'b0;
    d = bubble();
    tick();

    // Condition sweep: 16 conds x 16 flag values from the table.
    for (int i = 0; i < 256; i++) begin
      d = mk(4'b1110, 2'b11, 1'b0, 1'b0);
      tick();
      alu_flags = vecs[i].flags;
      d = mk(vecs[i].cond, 2'b00, 1'b1, 1'b1);
      tick();
      chk("sweep_flags", 32'(Flags), 32'(vecs[i].flags));
      chk("sweep_condex", 32'(CondExE), 32'(vecs[i].exp_pass));
      chk("sweep_branch", 32'(BranchTakenE), 32'(vecs[i].exp_pass));
    end

    // Randomized traffic with stalls, flushes and occasional reset.
    for (int i = 0; i < 400; i++) begin
      d         = rand_instr();
      alu_flags = 4'($urandom_range(0, 15));
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
